sparse_expand: RTL and testbench
================================

# sparse_expand

Sparse-to-dense expander on the receive side of the sparse channel path: accepts a stream of (channel address, value) entries, one frame at a time, and rebuilds the full `channel_num`-wide dense vector with a per-channel occupancy mask. It is the inverse of the compression side, where a first-set-bit search walks a dense vector and emits only the nonzero channels. Output frames are registered and held under a valid/ready handshake until consumed.

## Interface
- `n`, default `channel_num` (from `params.vh`): number of dense channels.
- `logn`, default `channel_num_log`: address width, `ceil(log2(n))`.
- `W`, default 16: value width per channel.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  entry present.
- `in_ready`  out  1  entry accepted when `in_valid & in_ready`.
- `in_addr`  in  `logn`  destination channel.
- `in_data`  in  `W`  channel value.
- `in_last`  in  1  final entry of the frame.
- `in_nop`  in  1  entry carries no data (closes an all-zero frame); `in_addr` and `in_data` are ignored.
- `out_valid`  out  1  dense frame available.
- `out_ready`  in  1  consumer takes the frame.
- `out_data`  out  `n*W`  channel `i` at bits `[i*W +: W]`.
- `out_mask`  out  `n`  bit `i` set if channel `i` was written this frame.
- `out_count`  out  `logn+1`  number of data entries written this frame, saturating at `n`.
- `dup_err`  out  1  one-cycle pulse on a duplicate address.
- `range_err`  out  1  one-cycle pulse on `in_addr >= n`.

## Operation
- Two states: FILL and HOLD. Reset state is FILL.
- In FILL, `in_ready = 1`. In HOLD, `in_ready = 0`. `in_ready` is a pure decode of state.
- **Accepted data entry** (`in_nop = 0`, `in_addr < n`):
  - Write `in_data` to the buffer at channel `in_addr`.
  - Set the mask bit for that channel.
  - Increment `count`, saturating at `n`.
  - If the mask bit was already set: the new value overwrites, the count still increments (saturating), and `dup_err` pulses.
- **Accepted entry with `in_addr >= n`**: no write, no mask change, no count change. `range_err` pulses.
- **Accepted `in_nop` entry**: no write, no mask change, no count change, no error pulse.
- **`in_last` on any accepted entry** (data, nop, or out-of-range): its own effect applies first, then the state moves to HOLD.
- **HOLD**:
  - `out_valid = 1`.
  - `out_data`, `out_mask` and `out_count` are stable until the handshake.
  - On `out_valid & out_ready`: clear the buffer, mask and count to zero, and return to FILL.
- Channels not written in a frame read as 0 in `out_data`.
- **Reset asserted mid-frame**: the partial frame is discarded and every register clears immediately.
- **Reset values**:
  - `out_valid = 0`, `in_ready = 1`.
  - `out_data`, `out_mask` and `out_count` all 0.
  - `dup_err = 0`, `range_err = 0`.

## Timing
- Entry accepted at edge k → buffer, mask and count updated after edge k.
- Last entry accepted at edge k → `out_valid` high from cycle k+1.
- Handshake at edge j → `out_valid` low and `in_ready` high in cycle j+1. The first entry of the next frame can be accepted at edge j+1.
- Throughput: one frame per (entries + 1) cycles when the consumer is always ready.
- `dup_err` and `range_err` are registered and high exactly in cycle k+1 for an offending entry accepted at edge k.
- No combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Simultaneous `in_valid` and `out_ready` are harmless: the two are never active in the same state.

## Structure
- Package `sparse_pkg` holds:
  - `channel_num`, `channel_num_log` and `W`;
  - the state enum (`ST_FILL`, `ST_HOLD`);
  - a helper for the channel slice offset `i*W`.
- Sub-module `addr_decode`: combinational `logn`-to-`n` one-hot decoder with an out-of-range flag. It drives the per-channel write enables and the `range_err` source.
- Buffer: `n` registers of `W` bits with per-channel enable and a synchronous clear on handshake.

## Test plan
All scenarios use `n=8`, `W=16`.
- **Basic frame**: entries (2, 0x00AA), (5, 0x0BBB, last) → in cycle k+1, `out_mask=8'b0010_0100`, channel 2 = 0x00AA, channel 5 = 0x0BBB, other channels 0, `out_count=2`.
- **Backpressure**: hold `out_ready=0` for 10 cycles after `out_valid` → `in_ready=0` and outputs frozen throughout. Raising `out_ready` → next cycle `out_valid=0`, `in_ready=1`, buffer cleared.
- **Duplicate address**: (3, 0x1111), (3, 0x2222, last) → `dup_err` high one cycle, channel 3 = 0x2222, `out_mask=8'b0000_1000`, `out_count=2`.
- **Empty frame**: single `in_nop=1, in_last=1` entry → `out_valid`, `out_mask=0`, `out_data=0`, `out_count=0`, no error pulses.
- **Out-of-range address**: run with `n=6`: entry `in_addr=7`, `last` → `range_err` pulses, `out_mask=0`, `out_count=0`.
- **Mid-frame reset**: assert `rst` after 3 of 5 entries, then deassert → all outputs at reset values. A new 1-entry frame (0, 0xFFFF, last) yields `out_mask=8'b0000_0001` with no stale data.

Source files
------------

// File: rtl/sparse_expand_pkg.sv
// Shared constants, FSM state type and slice helper for the sparse channel receive path.
package sparse_pkg;

  localparam int channel_num     = 8;
  localparam int channel_num_log = 3;
  localparam int W               = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int slice_off(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/sparse_expand_addr_decode.sv
// Channel address to one-hot write-enable decoder with an out-of-range flag.
module addr_decode #(
  parameter int n    = sparse_pkg::channel_num,
  parameter int logn = sparse_pkg::channel_num_log
) (
  input  logic [logn-1:0] addr_i,
  output logic [n-1:0]    onehot_o,
  output logic            oor_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < n; i++) begin
      onehot_o[i] = (addr_i == logn'(i));
    end
    oor_o = (int'(addr_i) >= n);
  end

endmodule

// File: rtl/sparse_expand.sv
// Rebuilds a dense channel vector plus occupancy mask from (address, value) entries,
// holding each completed frame under a valid/ready handshake.
module sparse_expand #(
  parameter int n    = sparse_pkg::channel_num,
  parameter int logn = sparse_pkg::channel_num_log,
  parameter int W    = sparse_pkg::W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [logn-1:0] in_addr,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  input  logic            in_nop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n*W-1:0]  out_data,
  output logic [n-1:0]    out_mask,
  output logic [logn:0]   out_count,
  output logic            dup_err,
  output logic            range_err
);
  import sparse_pkg::*;

  localparam int CW = logn + 1;

  state_e        state_q, state_d;
  logic [W-1:0]  chan_q [n];
  logic [W-1:0]  chan_d [n];
  logic [n-1:0]  mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;
  logic          dup_q, dup_d;
  logic          range_q, range_d;

  logic [n-1:0]  sel;
  logic          oor;
  logic          accept, wr, handshake;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(n)) ? c : c + CW'(1);
  endfunction

  addr_decode #(
    .n    (n),
    .logn (logn)
  ) u_addr_decode (
    .addr_i   (in_addr),
    .onehot_o (sel),
    .oor_o    (oor)
  );

  // Handshake signals are pure decodes of the state register.
  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign wr        = accept & ~in_nop & ~oor;
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    dup_d   = 1'b0;
    range_d = 1'b0;
    for (int i = 0; i < n; i++) begin
      chan_d[i] = chan_q[i];
    end

    if (handshake) begin
      mask_d  = '0;
      count_d = '0;
      for (int i = 0; i < n; i++) begin
        chan_d[i] = '0;
      end
      state_d = ST_FILL;
    end else if (accept) begin
      if (wr) begin
        mask_d  = mask_q | sel;
        count_d = sat_inc(count_q);
        dup_d   = |(mask_q & sel);
        for (int i = 0; i < n; i++) begin
          if (sel[i]) chan_d[i] = in_data;
        end
      end
      range_d = ~in_nop & oor;
      if (in_last) state_d = ST_HOLD;
    end
  end

  // Single register stage: every piece of state clears on reset so a partial frame is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      range_q <= 1'b0;
      for (int i = 0; i < n; i++) begin
        chan_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      range_q <= range_d;
      for (int i = 0; i < n; i++) begin
        chan_q[i] <= chan_d[i];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < n; i++) begin
      out_data[slice_off(i, W) +: W] = chan_q[i];
    end
  end

  assign out_mask  = mask_q;
  assign out_count = count_q;
  assign dup_err   = dup_q;
  assign range_err = range_q;

endmodule

// File: tb/tb_sparse_expand.sv
// Self-checking bench: an 8-channel and a 6-channel expander share one input stream.
module tb_sparse_expand;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, in_nop, out_ready;
  logic [2:0]  in_addr;
  logic [15:0] in_data;

  logic         ir8, ov8, dup8, rng8;
  logic [127:0] od8;
  logic [7:0]   om8;
  logic [3:0]   oc8;
  logic         ir6, ov6, dup6, rng6;
  logic [95:0]  od6;
  logic [5:0]   om6;
  logic [3:0]   oc6;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: per-instance channel contents, occupancy and count.
  int          NN [2] = '{8, 6};
  logic [15:0] m_data [2][8];
  logic [7:0]  m_mask [2];
  int          m_cnt  [2];
  logic        exp_dup [2];
  logic        exp_rng [2];
  logic        last_rng6, last_dup8;

  always #5 clk = ~clk;

  sparse_expand #(.n(8), .logn(3), .W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .in_nop(in_nop), .out_valid(ov8),
    .out_ready(out_ready), .out_data(od8), .out_mask(om8), .out_count(oc8),
    .dup_err(dup8), .range_err(rng8)
  );

  sparse_expand #(.n(6), .logn(3), .W(16)) u6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .in_nop(in_nop), .out_valid(ov6),
    .out_ready(out_ready), .out_data(od6), .out_mask(om6), .out_count(oc6),
    .dup_err(dup6), .range_err(rng6)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_mask[k] = '0;
      m_cnt[k]  = 0;
      for (int i = 0; i < 8; i++) m_data[k][i] = '0;
    end
  endtask

  task automatic model_apply(input int addr, input logic [15:0] data, input logic nop);
    for (int k = 0; k < 2; k++) begin
      exp_dup[k] = 1'b0;
      exp_rng[k] = 1'b0;
      if (!nop) begin
        if (addr >= NN[k]) begin
          exp_rng[k] = 1'b1;
        end else begin
          exp_dup[k]       = m_mask[k][addr];
          m_mask[k][addr]  = 1'b1;
          m_data[k][addr]  = data;
          m_cnt[k]         = (m_cnt[k] < NN[k]) ? m_cnt[k] + 1 : m_cnt[k];
        end
      end
    end
  endtask

  task automatic check_state(input string tag, input logic hold);
    logic [127:0] e8, e6;
    e8 = '0;
    e6 = '0;
    for (int i = 0; i < 8; i++) e8[i*16 +: 16] = m_data[0][i];
    for (int i = 0; i < 6; i++) e6[i*16 +: 16] = m_data[1][i];
    check({tag, "_valid8"}, 128'(ov8), 128'(hold));
    check({tag, "_ready8"}, 128'(ir8), 128'(!hold));
    check({tag, "_mask8"},  128'(om8), 128'(m_mask[0]));
    check({tag, "_count8"}, 128'(oc8), 128'(m_cnt[0]));
    check({tag, "_data8"},  od8, e8);
    check({tag, "_valid6"}, 128'(ov6), 128'(hold));
    check({tag, "_ready6"}, 128'(ir6), 128'(!hold));
    check({tag, "_mask6"},  128'(om6), 128'(m_mask[1][5:0]));
    check({tag, "_count6"}, 128'(oc6), 128'(m_cnt[1]));
    check({tag, "_data6"},  128'(od6), e6);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dup8"}, 128'(dup8), 128'(0));
    check({tag, "_rng8"}, 128'(rng8), 128'(0));
    check({tag, "_dup6"}, 128'(dup6), 128'(0));
    check({tag, "_rng6"}, 128'(rng6), 128'(0));
  endtask

  // Called just after a rising edge; leaves the bench just after the accepting edge.
  task automatic send(input string tag, input int addr, input logic [15:0] data,
                      input logic last, input logic nop);
    check({tag, "_inready"}, 128'(ir8 & ir6), 128'(1));
    in_valid = 1'b1;
    in_addr  = 3'(addr);
    in_data  = data;
    in_last  = last;
    in_nop   = nop;
    @(posedge clk);
    model_apply(addr, data, nop);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_nop   = 1'b0;
    in_addr  = 3'($urandom);
    in_data  = 16'($urandom);
    last_rng6 = rng6;
    last_dup8 = dup8;
    check({tag, "_dup8"}, 128'(dup8), 128'(exp_dup[0]));
    check({tag, "_rng8"}, 128'(rng8), 128'(exp_rng[0]));
    check({tag, "_dup6"}, 128'(dup6), 128'(exp_dup[1]));
    check({tag, "_rng6"}, 128'(rng6), 128'(exp_rng[1]));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    model_clear();
    check_state({tag, "_cleared"}, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nop    = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    #12;
    check_state("reset", 1'b0);
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame
    send("basic0", 2, 16'h00AA, 1'b0, 1'b0);
    send("basic1", 5, 16'h0BBB, 1'b1, 1'b0);
    check("basic_mask", 128'(om8), 128'(8'b0010_0100));
    check("basic_ch2", 128'(od8[2*16 +: 16]), 128'(16'h00AA));
    check("basic_ch5", 128'(od8[5*16 +: 16]), 128'(16'h0BBB));
    check("basic_count", 128'(oc8), 128'(2));
    check_state("basic", 1'b1);

    // Backpressure: frame must stay frozen
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_state("bp", 1'b1);
      check_quiet("bp");
    end
    consume("bp");

    // Duplicate address
    send("dup0", 3, 16'h1111, 1'b0, 1'b0);
    send("dup1", 3, 16'h2222, 1'b1, 1'b0);
    check("dup_pulse", 128'(last_dup8), 128'(1));
    check("dup_ch3", 128'(od8[3*16 +: 16]), 128'(16'h2222));
    check("dup_mask", 128'(om8), 128'(8'b0000_1000));
    check("dup_count", 128'(oc8), 128'(2));
    @(posedge clk);
    #1;
    check_quiet("dup_after");
    consume("dup");

    // Empty frame
    send("empty", 0, 16'h5A5A, 1'b1, 1'b1);
    check("empty_valid", 128'(ov8), 128'(1));
    check("empty_mask", 128'(om8), 128'(0));
    check("empty_data", od8, 128'(0));
    check("empty_count", 128'(oc8), 128'(0));
    consume("empty");

    // Out-of-range on the 6-channel instance
    send("range", 7, 16'h1234, 1'b1, 1'b0);
    check("range_pulse6", 128'(last_rng6), 128'(1));
    check("range_mask6", 128'(om6), 128'(0));
    check("range_count6", 128'(oc6), 128'(0));
    check("range_valid6", 128'(ov6), 128'(1));
    check_state("range", 1'b1);
    consume("range");

    // Mid-frame reset after 3 of 5 entries
    send("mr0", 1, 16'hAAAA, 1'b0, 1'b0);
    send("mr1", 4, 16'hBBBB, 1'b0, 1'b0);
    send("mr2", 1, 16'hCCCC, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_state("midrst", 1'b0);
    check_quiet("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send("post", 0, 16'hFFFF, 1'b1, 1'b0);
    check("post_mask", 128'(om8), 128'(8'b0000_0001));
    check("post_data", od8, 128'(16'hFFFF));
    check("post_count", 128'(oc8), 128'(1));
    consume("post");

    // Randomized frames, including saturation and range errors on the 6-channel instance
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        send("rnd", $urandom_range(0, 7), 16'($urandom), j == len - 1,
             $urandom_range(0, 7) == 0);
      end
      check_state("rnd_frame", 1'b1);
      for (int c = $urandom_range(0, 3); c > 0; c--) begin
        @(posedge clk);
        #1;
        check_state("rnd_wait", 1'b1);
      end
      consume("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
